// File: rtl/can_pkg.sv
// Shared types and defaults for the CAN transmit control unit.
package can_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_LATCH   = 3'd2,
    S_REQUEST = 3'd3,
    S_ACTIVE  = 3'd4
  } cu_state_t;

  typedef logic [127:0] can_msg_t;

  localparam logic [2:0] CAN_MAX_RETRY_DEF = 3'd7;

endpackage

// File: rtl/can_tx_cu.sv
// CAN transmit control unit: pops one frame from the TX FIFO, hands it to the
// BSP, and handles retry on error, re-arbitration on loss, and software abort.
//   state   | meaning
//   IDLE    | waiting for a non-empty FIFO
//   FETCH   | FIFO read strobe
//   LATCH   | capture FIFO word, reset retry/abort bookkeeping
//   REQUEST | request the bus from the BSP
//   ACTIVE  | frame on the bus, waiting for done/err/arb_lost
module can_tx_cu
  import can_pkg::*;
#(
  parameter logic [2:0] MAX_RETRY = CAN_MAX_RETRY_DEF
) (
  input  logic         i_cu_sys_clk,
  input  logic         i_cu_reset,
  input  logic         i_cu_tx_empty,
  output logic         o_cu_tx_r_en,
  input  logic [127:0] i_cu_tx_fifo_r_data,
  output logic         o_cu_tx_req,
  output logic [127:0] o_cu_tx_message,
  input  logic         i_cu_tx_ack,
  input  logic         i_cu_tx_done,
  input  logic         i_cu_arb_lost,
  input  logic         i_cu_tx_err,
  input  logic         i_cu_abort,
  output logic         o_cu_txbsy,
  output logic         o_cu_tx_ok,
  output logic         o_cu_tx_fail,
  output logic [2:0]   o_cu_retry_cnt
);

  cu_state_t  r_state;
  can_msg_t   r_message;
  logic [2:0] r_retry_cnt;
  logic       r_abort_pend;
  logic       r_r_en;
  logic       r_tx_req;
  logic       r_txbsy;
  logic       r_tx_ok;
  logic       r_tx_fail;

  cu_state_t  w_state_nxt;
  logic [2:0] w_retry_nxt;
  logic       w_abort_nxt;
  logic       w_ok_nxt;
  logic       w_fail_nxt;
  logic       w_abort_any;

  // An abort arriving in the same cycle as an ACTIVE event counts as pending.
  assign w_abort_any = r_abort_pend | i_cu_abort;

  always_comb begin
    w_state_nxt = r_state;
    w_retry_nxt = r_retry_cnt;
    w_abort_nxt = r_abort_pend;
    w_ok_nxt    = 1'b0;
    w_fail_nxt  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!i_cu_tx_empty) w_state_nxt = S_FETCH;
      end
      S_FETCH: w_state_nxt = S_LATCH;
      S_LATCH: begin
        w_state_nxt = S_REQUEST;
        w_retry_nxt = 3'd0;
        w_abort_nxt = 1'b0;
      end
      S_REQUEST: begin
        if (i_cu_abort) begin
          w_state_nxt = S_IDLE;
          w_fail_nxt  = 1'b1;
        end else if (i_cu_tx_ack) begin
          w_state_nxt = S_ACTIVE;
        end
      end
      S_ACTIVE: begin
        if (i_cu_abort) w_abort_nxt = 1'b1;
        if (i_cu_tx_done) begin
          w_state_nxt = S_IDLE;
          w_ok_nxt    = 1'b1;
        end else if (i_cu_tx_err) begin
          if (w_abort_any || (r_retry_cnt == MAX_RETRY)) begin
            w_state_nxt = S_IDLE;
            w_fail_nxt  = 1'b1;
          end else begin
            w_state_nxt = S_REQUEST;
            w_retry_nxt = r_retry_cnt + 3'd1;
          end
        end else if (i_cu_arb_lost) begin
          if (w_abort_any) begin
            w_state_nxt = S_IDLE;
            w_fail_nxt  = 1'b1;
          end else begin
            w_state_nxt = S_REQUEST;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they line up with r_state.
  always_ff @(posedge i_cu_sys_clk) begin
    if (i_cu_reset) begin
      r_state      <= S_IDLE;
      r_message    <= '0;
      r_retry_cnt  <= 3'd0;
      r_abort_pend <= 1'b0;
      r_r_en       <= 1'b0;
      r_tx_req     <= 1'b0;
      r_txbsy      <= 1'b0;
      r_tx_ok      <= 1'b0;
      r_tx_fail    <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_retry_cnt  <= w_retry_nxt;
      r_abort_pend <= w_abort_nxt;
      if (r_state == S_LATCH) r_message <= i_cu_tx_fifo_r_data;
      r_r_en       <= (w_state_nxt == S_FETCH);
      r_tx_req     <= (w_state_nxt == S_REQUEST);
      r_txbsy      <= (w_state_nxt != S_IDLE);
      r_tx_ok      <= w_ok_nxt;
      r_tx_fail    <= w_fail_nxt;
    end
  end

  assign o_cu_tx_r_en    = r_r_en;
  assign o_cu_tx_req     = r_tx_req;
  assign o_cu_tx_message = r_message;
  assign o_cu_txbsy      = r_txbsy;
  assign o_cu_tx_ok      = r_tx_ok;
  assign o_cu_tx_fail    = r_tx_fail;
  assign o_cu_retry_cnt  = r_retry_cnt;

endmodule

// File: tb/tb_can_tx_cu.sv
// Directed bench for can_tx_cu: a cycle table plus hand sequences for retry,
// abort and reset corners. A second instance keeps the default retry limit.
module tb_can_tx_cu;
  import can_pkg::*;

  logic         clk = 1'b0;
  logic         rst, empty, ack, done, arb, err, abort;
  logic [127:0] rdata;

  logic         ren, req, bsy, ok, fail;
  logic [127:0] msg;
  logic [2:0]   retry;
  logic         ren7, req7, bsy7, ok7, fail7;
  logic [127:0] msg7;
  logic [2:0]   retry7;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  can_tx_cu #(.MAX_RETRY(3'd2)) u_dut (
    .i_cu_sys_clk(clk), .i_cu_reset(rst), .i_cu_tx_empty(empty),
    .o_cu_tx_r_en(ren), .i_cu_tx_fifo_r_data(rdata), .o_cu_tx_req(req),
    .o_cu_tx_message(msg), .i_cu_tx_ack(ack), .i_cu_tx_done(done),
    .i_cu_arb_lost(arb), .i_cu_tx_err(err), .i_cu_abort(abort),
    .o_cu_txbsy(bsy), .o_cu_tx_ok(ok), .o_cu_tx_fail(fail),
    .o_cu_retry_cnt(retry)
  );

  can_tx_cu u_dut7 (
    .i_cu_sys_clk(clk), .i_cu_reset(rst), .i_cu_tx_empty(empty),
    .o_cu_tx_r_en(ren7), .i_cu_tx_fifo_r_data(rdata), .o_cu_tx_req(req7),
    .o_cu_tx_message(msg7), .i_cu_tx_ack(ack), .i_cu_tx_done(done),
    .i_cu_arb_lost(arb), .i_cu_tx_err(err), .i_cu_abort(abort),
    .o_cu_txbsy(bsy7), .o_cu_tx_ok(ok7), .o_cu_tx_fail(fail7),
    .o_cu_retry_cnt(retry7)
  );

  typedef struct {
    logic       rst, empty, ack, done, arb, err, abort;
    logic       ren, req, bsy, ok, fail;
    logic [2:0] retry;
  } vec_t;

  vec_t vt[$];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic cyc(input logic r, e, a, d, l, x, b);
    rst = r; empty = e; ack = a; done = d; arb = l; err = x; abort = b;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cyc();
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Leaves the DUT in REQUEST with the given word latched.
  task automatic fetch_frame(input logic [127:0] d);
    rdata = d;
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle_cyc();
    idle_cyc();
  endtask

  task automatic chk_outs(input string nm, input logic e_ren, e_req, e_bsy, e_ok, e_fail,
                          input logic [2:0] e_retry);
    chk({nm, ".r_en"},  ren,   e_ren);
    chk({nm, ".req"},   req,   e_req);
    chk({nm, ".bsy"},   bsy,   e_bsy);
    chk({nm, ".ok"},    ok,    e_ok);
    chk({nm, ".fail"},  fail,  e_fail);
    chk({nm, ".retry"}, retry, e_retry);
  endtask

  initial begin
    logic [127:0] a5;
    int n_ren, n_ok, n_fl;
    a5 = {16{8'hA5}};
    rst = 1'b1; empty = 1'b1; ack = 1'b0; done = 1'b0;
    arb = 1'b0; err = 1'b0; abort = 1'b0; rdata = '0;

    // rst empty ack done arb err abort | ren req bsy ok fail retry
    vt.push_back('{1,1,0,0,0,0,0, 0,0,0,0,0,3'd0});  // reset
    vt.push_back('{0,0,0,0,0,0,0, 1,0,1,0,0,3'd0});  // -> FETCH
    vt.push_back('{0,1,0,0,0,0,0, 0,0,1,0,0,3'd0});  // -> LATCH
    vt.push_back('{0,1,0,0,0,0,0, 0,1,1,0,0,3'd0});  // -> REQUEST
    vt.push_back('{0,1,1,0,0,0,0, 0,0,1,0,0,3'd0});  // ack -> ACTIVE
    vt.push_back('{0,1,0,0,1,0,0, 0,1,1,0,0,3'd0});  // arb_lost 1
    vt.push_back('{0,1,1,0,0,0,0, 0,0,1,0,0,3'd0});
    vt.push_back('{0,1,0,0,1,0,0, 0,1,1,0,0,3'd0});  // arb_lost 2
    vt.push_back('{0,1,1,0,0,0,0, 0,0,1,0,0,3'd0});
    vt.push_back('{0,1,0,0,1,0,0, 0,1,1,0,0,3'd0});  // arb_lost 3
    vt.push_back('{0,1,0,1,0,0,0, 0,1,1,0,0,3'd0});  // done in REQUEST ignored
    vt.push_back('{0,1,1,0,0,0,0, 0,0,1,0,0,3'd0});
    vt.push_back('{0,1,0,1,0,0,0, 0,0,0,1,0,3'd0});  // done -> ok
    vt.push_back('{0,1,0,0,0,0,0, 0,0,0,0,0,3'd0});  // ok is one cycle
    vt.push_back('{0,1,1,1,1,1,1, 0,0,0,0,0,3'd0});  // events in IDLE ignored

    foreach (vt[i]) begin
      cyc(vt[i].rst, vt[i].empty, vt[i].ack, vt[i].done, vt[i].arb, vt[i].err, vt[i].abort);
      chk_outs($sformatf("vec%0d", i), vt[i].ren, vt[i].req, vt[i].bsy,
               vt[i].ok, vt[i].fail, vt[i].retry);
    end

    // Single frame: ack at cycle 6, done at cycle 40.
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("rst.msg", msg, '0);
    rdata = a5;
    n_ren = 0; n_ok = 0; n_fl = 0;
    for (int c = 0; c < 45; c++) begin
      cyc(1'b0, (c != 0), (c == 6), (c == 40), 1'b0, 1'b0, 1'b0);
      n_ren += int'(ren);
      n_ok  += int'(ok);
      n_fl  += int'(fail);
    end
    chk("frame.ren_cycles", n_ren, 1);
    chk("frame.ok_pulses", n_ok, 1);
    chk("frame.fail_pulses", n_fl, 0);
    chk("frame.msg", msg, a5);
    chk("frame.retry", retry, 0);
    chk("frame.bsy", bsy, 0);
    rdata = '0;
    idle_cyc();
    chk("frame.msg_held", msg, a5);

    // Error on every attempt: limit 2 fails after the third error.
    fetch_frame({8{16'h1111}});
    for (int k = 0; k < 3; k++) begin
      cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      if (k < 2) begin
        chk($sformatf("retry.req%0d", k), req, 1'b1);
        chk($sformatf("retry.cnt%0d", k), retry, 3'(k + 1));
        chk($sformatf("retry.fail%0d", k), fail, 1'b0);
      end
    end
    chk("retry.fail", fail, 1'b1);
    chk("retry.bsy", bsy, 1'b0);
    chk("retry.final_cnt", retry, 3'd2);
    chk("retry7.cnt", retry7, 3'd3);
    chk("retry7.req", req7, 1'b1);
    chk("retry7.fail", fail7, 1'b0);
    idle_cyc();
    chk("retry.fail_clear", fail, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("retry7.rst_bsy", bsy7, 1'b0);
    chk("retry7.rst_cnt", retry7, 3'd0);
    chk("retry7.rst_msg", msg7, '0);

    // Abort in REQUEST wins over a simultaneous ack.
    fetch_frame(128'h1);
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    chk_outs("abort_req", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0);
    idle_cyc();
    chk("abort_req.fail_clear", fail, 1'b0);

    // Abort in ACTIVE, then done: frame still completes ok.
    fetch_frame(128'h2);
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk_outs("abort_act", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0);
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk_outs("abort_done", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0);

    // Abort in ACTIVE, then err: fail with no retry.
    fetch_frame(128'h3);
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk_outs("abort_err", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0);

    // Pending abort must not leak into the next frame.
    fetch_frame(128'h4);
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk_outs("pend_cleared", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0);
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    // done and err together: ok only.
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    chk_outs("done_err", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0);

    // Reset in ACTIVE, with a coincident done: no completion pulse.
    fetch_frame(128'h5);
    chk("rst_act.msg_pre", msg, 128'h5);
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk_outs("rst_act", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
    chk("rst_act.msg", msg, '0);
    idle_cyc();
    chk_outs("rst_act.after", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);

    // Reset during FETCH: no second read once released with FIFO empty.
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("rst_fetch.ren_pre", ren, 1'b1);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk_outs("rst_fetch", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
    idle_cyc();
    chk_outs("rst_fetch.after", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  always @(negedge clk) begin
    if (ok && fail) begin
      n_checks++;
      n_fail++;
      $display("FAIL ok_fail_exclusive: ok=%0b fail=%0b, required not both high", ok, fail);
    end
  end

endmodule

// File: doc/can_tx_cu.md
CAN_TX_CU -- requirements
Module: can_tx_cu

Interface
REQ-001 SHALL have parameter MAX_RETRY, default 7, the number of error-triggered retries allowed per frame (3-bit, 0..7).
REQ-002 SHALL have port i_cu_sys_clk, input, 1, the single system clock; all logic is on its rising edge.
REQ-003 SHALL have port i_cu_reset, input, 1, reset, synchronous and active-high.
REQ-004 SHALL have port i_cu_tx_empty, input, 1, TX FIFO empty flag.
REQ-005 SHALL have port o_cu_tx_r_en, output, 1, TX FIFO read strobe.
REQ-006 SHALL have port i_cu_tx_fifo_r_data, input, 128, TX FIFO read data, valid the cycle after o_cu_tx_r_en.
REQ-007 SHALL have port o_cu_tx_req, output, 1, frame request to the bit-stream processor (BSP).
REQ-008 SHALL have port o_cu_tx_message, output, 128, held frame presented to the BSP.
REQ-009 SHALL have port i_cu_tx_ack, input, 1, BSP has started the frame (SOF sent).
REQ-010 SHALL have port i_cu_tx_done, input, 1, single-cycle pulse: frame sent and ACKed.
REQ-011 SHALL have port i_cu_arb_lost, input, 1, single-cycle pulse: arbitration lost.
REQ-012 SHALL have port i_cu_tx_err, input, 1, single-cycle pulse: bus or ACK error during the frame.
REQ-013 SHALL have port i_cu_abort, input, 1, software abort request, level or pulse.
REQ-014 SHALL have port o_cu_txbsy, output, 1, controller busy.
REQ-015 SHALL have ports o_cu_tx_ok and o_cu_tx_fail, output, 1 each, single-cycle completion pulses.
REQ-016 SHALL have port o_cu_retry_cnt, output, 3, error retries used for the current frame.

Function
REQ-017 SHALL implement an FSM with states IDLE, FETCH, LATCH, REQUEST and ACTIVE.
REQ-018 IDLE: when i_cu_tx_empty=0, go to FETCH; otherwise stay.
REQ-019 FETCH: assert o_cu_tx_r_en for exactly this one cycle, then go to LATCH.
REQ-020 LATCH: capture i_cu_tx_fifo_r_data into the message register, clear the retry count and the abort-pending flag, then go to REQUEST.
REQ-021 REQUEST: assert o_cu_tx_req.
- i_cu_abort=1 -> go to IDLE and pulse o_cu_tx_fail (abort takes priority over ack).
- else i_cu_tx_ack=1 -> go to ACTIVE.
REQ-022 ACTIVE: o_cu_tx_req=0; i_cu_abort=1 sets the abort-pending flag and does not interrupt the frame. Event priority: done > err > arb_lost.
- done -> IDLE, pulse o_cu_tx_ok (even if abort is pending).
- err with abort pending, or with retry count = MAX_RETRY -> IDLE, pulse o_cu_tx_fail.
- err otherwise -> increment retry count, go to REQUEST.
- arb_lost with abort pending -> IDLE, pulse o_cu_tx_fail.
- arb_lost otherwise -> REQUEST, retry count unchanged (arbitration loss never counts).
REQ-023 o_cu_tx_ok and o_cu_tx_fail SHALL be registered, pulse one cycle after the terminating event, and never both be high.
REQ-024 o_cu_tx_message SHALL hold its value from LATCH until the next LATCH; it is not cleared on completion.
REQ-025 o_cu_txbsy SHALL be 1 in every state except IDLE.
REQ-026 Completion SHALL go to IDLE first, so a non-empty FIFO is fetched again no earlier than 1 cycle after completion (no back-to-back read).
REQ-027 Events arriving in IDLE, FETCH or LATCH (ack, done, err, arb_lost) SHALL be ignored; abort in those states SHALL also be ignored.
REQ-028 The retry counter SHALL saturate at MAX_RETRY and never wrap.

Reset
REQ-029 On i_cu_reset=1 at a clock edge, including mid-frame, SHALL enter IDLE and clear all outputs: r_en=0, tx_req=0, tx_message=0, txbsy=0, tx_ok=0, tx_fail=0, retry_cnt=0. The abort-pending flag SHALL clear.
REQ-030 A reset during FETCH SHALL not re-read the FIFO; the popped word is discarded.

Structure
REQ-031 The state enum, the 128-bit message type and the default MAX_RETRY SHALL reside in shared package can_pkg.
REQ-032 SHALL be a single module with no submodules; the FSM state register and the message/retry registers are in one clocked block, with next-state logic combinational.

Verification
REQ-033 FIFO non-empty with word 128'hA5..A5; ack at cycle 6, done at cycle 40 -> r_en high 1 cycle, tx_message=A5..A5, tx_ok pulses once, retry_cnt=0.
REQ-034 Three arb_lost events, then done -> tx_req reasserts 3 times, retry_cnt stays 0, tx_ok pulses.
REQ-035 MAX_RETRY=2 with err on every attempt -> exactly 3 ack/err cycles, retry_cnt reaches 2, tx_fail pulses, FSM in IDLE.
REQ-036 Abort in REQUEST -> IDLE next cycle, tx_fail pulses. Abort in ACTIVE followed by done -> tx_ok. Abort in ACTIVE followed by err -> tx_fail with no retry.
REQ-037 done and err asserted in the same cycle -> tx_ok only. Reset asserted in ACTIVE -> all outputs 0 next cycle, no completion pulse.
